// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer writer: default geometry, colour width, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fb_pkg;

  localparam int FB_W_DEF   = 160;
  localparam int FB_H_DEF   = 120;
  localparam int ADDR_W_DEF = 15;
  localparam int COLOR_W    = 24;  // RGB888

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    CLEAR = 2'b10
  } fb_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO buffering clipped pixels ({addr, colour}) between rasterizer and memory port.
// Latency: a push is visible at the head (empty=0) the cycle after the push edge; the head is read combinationally.
// Backpressure: none upstream; pushes while full and pops while empty are ignored, the caller gates them.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (pointers only)
//   push, push_dat    write strobe and entry
//   pop, pop_dat      read strobe and current head entry
//   full, empty       status derived from the extended pointers
module pixel_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra MSB distinguishes full (MSBs differ) from empty (identical).
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign pop_dat = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_dat;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel sink: clips and linearises rasterizer pixels, buffers them, drains them to framebuffer memory; also clears the screen.
// Latency: pixel_valid at cycle N -> mem_wr_en at N+2 (idle, empty FIFO); 1 pixel/cycle sustained while mem_ready=1.
// Backpressure: mem_ready stalls the write port; the rasterizer cannot be stalled, so pixels arriving on a full FIFO are dropped (sticky overflow).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   px, py, pixel_color       rasterizer pixel, qualified by pixel_valid
//   draw_done                 end-of-shape pulse -> frame_done once all its pixels are written
//   clear_start, clear_color  full-screen clear request (taken only when idle with an empty FIFO)
//   mem_wr_en/addr/wdata      write port to the single-port framebuffer, transfer on mem_ready
//   busy, frame_done, overflow, clip_cnt   status
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         px,
  input  logic [7:0]         py,
  input  logic [COLOR_W-1:0] pixel_color,
  input  logic               pixel_valid,
  input  logic               draw_done,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow,
  output logic [15:0]        clip_cnt
);

  localparam int          FIFO_W   = ADDR_W + COLOR_W;
  localparam logic [8:0]  X_LIM    = 9'(FB_W);
  localparam logic [8:0]  Y_LIM    = 9'(FB_H);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  fb_state_t          r_state;
  logic               r_mem_wr_en;
  logic [ADDR_W-1:0]  r_mem_addr;   // doubles as the clear counter in CLEAR
  logic [COLOR_W-1:0] r_mem_wdata;  // holds the latched clear colour in CLEAR
  logic               r_overflow;
  logic [15:0]        r_clip_cnt;
  logic               r_done_pending;
  logic               r_frame_done;

  logic               w_in_bounds;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_hs;
  logic               w_fd_cond;
  logic [FIFO_W-1:0]  w_head;

  // ---------------- clip and linearise ----------------
  assign w_in_bounds = ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);
  assign w_addr      = ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);

  // Full is the pre-pop status: a pop in the same cycle does not rescue the pixel.
  assign w_push = pixel_valid & w_in_bounds & ~w_full;
  assign w_drop = pixel_valid & w_in_bounds &  w_full;

  assign w_hs  = r_mem_wr_en & mem_ready;
  assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == WRITE) & w_hs));

  pixel_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_dat ({w_addr, pixel_color}),
    .pop      (w_pop),
    .pop_dat  (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // ---------------- write / clear FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (clear_start && w_empty) begin
            // FIFO is empty here, so no drop can race with this clear.
            r_state     <= CLEAR;
            r_mem_addr  <= '0;
            r_mem_wdata <= clear_color;
            r_mem_wr_en <= 1'b1;
            r_overflow  <= 1'b0;
          end else if (!w_empty) begin
            r_state     <= WRITE;
            r_mem_addr  <= w_head[COLOR_W +: ADDR_W];
            r_mem_wdata <= w_head[COLOR_W-1:0];
            r_mem_wr_en <= 1'b1;
          end
        end
        WRITE: begin
          if (w_hs) begin
            if (!w_empty) begin
              r_mem_addr  <= w_head[COLOR_W +: ADDR_W];
              r_mem_wdata <= w_head[COLOR_W-1:0];
            end else begin
              r_mem_wr_en <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (w_hs) begin
            if (r_mem_addr == CLR_LAST) begin
              r_mem_wr_en <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_mem_addr <= r_mem_addr + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- clip counter (saturating) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clip_cnt <= '0;
    end else if (pixel_valid && !w_in_bounds && (r_clip_cnt != 16'hFFFF)) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  // ---------------- frame completion ----------------
  // A draw_done arriving while pending (or on the completing cycle) merges into the same pulse.
  assign w_fd_cond = r_done_pending & w_empty & ~r_mem_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_pending <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done   <= w_fd_cond;
      r_done_pending <= w_fd_cond ? 1'b0 : (r_done_pending | draw_done);
    end
  end

  assign mem_wr_en  = r_mem_wr_en;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign overflow   = r_overflow;
  assign clip_cnt   = r_clip_cnt;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != IDLE) | ~w_empty | r_done_pending;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    px, py;
  logic [23:0]   pixel_color;
  logic          pixel_valid, draw_done, clear_start;
  logic [23:0]   clear_color;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic          mem_ready;
  logic          busy, frame_done, overflow;
  logic [15:0]   clip_cnt;

  framebuffer_writer dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .pixel_color(pixel_color),
    .pixel_valid(pixel_valid), .draw_done(draw_done), .clear_start(clear_start),
    .clear_color(clear_color), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write log and frame_done pulse counter, sampled mid-cycle.
  logic [AW+23:0] wq[$];
  int fd_cnt = 0;
  always @(negedge clk) begin
    if (!rst && mem_wr_en && mem_ready) wq.push_back({mem_addr, mem_wdata});
    if (frame_done) fd_cnt++;
  end

  typedef struct {
    logic [7:0]    px;
    logic [7:0]    py;
    logic [23:0]   col;
    int            exp_wr;     // writes expected (0 when clipped)
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    while (busy && k < max) begin
      step();
      k++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic put_pixel(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
    px = x; py = y; pixel_color = c; pixel_valid = 1'b1;
  endtask

  initial begin
    int n0, fd0, wr_cyc, fd_cyc, bad, cyc, clip0;

    rst = 1'b1; px = '0; py = '0; pixel_color = '0; pixel_valid = 1'b0;
    draw_done = 1'b0; clear_start = 1'b0; clear_color = '0; mem_ready = 1'b1;
    vecs[0] = '{8'd0,   8'd0,   24'h123456, 1, 15'd0};
    vecs[1] = '{8'd159, 8'd0,   24'h00FF00, 1, 15'd159};
    vecs[2] = '{8'd0,   8'd1,   24'hABCDEF, 1, 15'd160};
    vecs[3] = '{8'd160, 8'd0,   24'h111111, 0, 15'd0};
    vecs[4] = '{8'd0,   8'd120, 24'h222222, 0, 15'd0};
    vecs[5] = '{8'd159, 8'd119, 24'h333333, 1, 15'd19199};
    vecs[6] = '{8'd255, 8'd255, 24'h444444, 0, 15'd0};
    vecs[7] = '{8'd37,  8'd77,  24'h0F0F0F, 1, 15'd12357};
    repeat (3) step();
    chk("reset_outputs", {mem_wr_en, busy, frame_done, overflow, clip_cnt, mem_addr, mem_wdata},
        64'd0);
    rst = 1'b0;
    step();

    // ---- single pixel, latency N+2, frame_done after the write ----
    fd0 = fd_cnt;
    put_pixel(8'd10, 8'd5, 24'hFF0000);
    step();
    pixel_valid = 1'b0; draw_done = 1'b1;
    chk("lat_n1_wr_en", 64'(mem_wr_en), 64'd0);
    step();
    draw_done = 1'b0;
    chk("lat_n2_wr_en", 64'(mem_wr_en), 64'd1);
    chk("lat_n2_addr", 64'(mem_addr), 64'd810);
    chk("lat_n2_data", 64'(mem_wdata), 64'hFF0000);
    step();
    chk("single_wr_done", 64'(mem_wr_en), 64'd0);
    step();
    chk("single_frame_done", 64'(frame_done), 64'd1);
    step();
    chk("single_frame_once", 64'(fd_cnt - fd0), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);

    // ---- table: addressing and clipping, one pixel at a time ----
    clip0 = int'(clip_cnt);
    for (int i = 0; i < 8; i++) begin
      n0 = wq.size();
      put_pixel(vecs[i].px, vecs[i].py, vecs[i].col);
      step();
      pixel_valid = 1'b0;
      repeat (5) step();
      chk($sformatf("vec%0d_nwr", i), 64'(wq.size() - n0), 64'(vecs[i].exp_wr));
      if (wq.size() > n0)
        chk($sformatf("vec%0d_wr", i), 64'(wq[n0]), 64'({vecs[i].exp_addr, vecs[i].col}));
    end
    chk("clip_cnt", 64'(int'(clip_cnt) - clip0), 64'd3);
    chk("clip_no_overflow", 64'(overflow), 64'd0);

    // ---- overflow burst: 20 pixels against a stalled memory ----
    // The head pixel moves into the write port before the FIFO fills,
    // so 1 + 16 pixels survive and the last 3 are dropped.
    mem_ready = 1'b0;
    n0 = wq.size();
    for (int i = 0; i < 20; i++) begin
      put_pixel(8'(i), 8'd2, 24'(i + 1));
      step();
    end
    pixel_valid = 1'b0;
    repeat (30) step();
    chk("burst_overflow", 64'(overflow), 64'd1);
    chk("burst_stalled", 64'(wq.size() - n0), 64'd0);
    mem_ready = 1'b1;
    wait_idle(200, "burst_drain_timeout");
    chk("burst_nwr", 64'(wq.size() - n0), 64'd17);
    bad = 0;
    for (int i = 0; i < 17; i++)
      if (n0 + i < wq.size() && wq[n0 + i] !== {15'(320 + i), 24'(i + 1)}) bad++;
    chk("burst_order", 64'(bad), 64'd0);

    // ---- full-screen clear, 50% ready, pixel pushed mid-clear ----
    n0 = wq.size();
    clear_start = 1'b1; clear_color = 24'h0000FF;
    step();
    clear_start = 1'b0; clear_color = 24'hDEAD00;
    cyc = 0;
    while ((busy || cyc < 110) && cyc < 60000) begin
      mem_ready = ~mem_ready;
      if (cyc == 100) put_pixel(8'd1, 8'd1, 24'h00AA55);
      else pixel_valid = 1'b0;
      step();
      cyc++;
    end
    mem_ready = 1'b1;
    chk("clear_timeout", 64'(busy), 64'd0);
    chk("clear_nwr", 64'(wq.size() - n0), 64'd19201);
    bad = 0;
    for (int i = 0; i < 19200; i++)
      if (n0 + i < wq.size() && wq[n0 + i] !== {15'(i), 24'h0000FF}) bad++;
    chk("clear_seq", 64'(bad), 64'd0);
    if (wq.size() == n0 + 19201)
      chk("clear_then_pixel", 64'(wq[n0 + 19200]), 64'({15'd161, 24'h00AA55}));
    chk("clear_resets_overflow", 64'(overflow), 64'd0);

    // ---- draw_done with pixel, then a merged second draw_done ----
    n0 = wq.size(); fd0 = fd_cnt; wr_cyc = -1; fd_cyc = -1;
    put_pixel(8'd3, 8'd3, 24'h777777);
    draw_done = 1'b1;
    step();
    pixel_valid = 1'b0;
    step();
    draw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (wr_cyc < 0 && wq.size() > n0) wr_cyc = c;
      if (fd_cyc < 0 && frame_done) fd_cyc = c;
      step();
    end
    chk("merge_one_pulse", 64'(fd_cnt - fd0), 64'd1);
    chk("merge_nwr", 64'(wq.size() - n0), 64'd1);
    if (wq.size() > n0) chk("merge_wr", 64'(wq[n0]), 64'({15'd483, 24'h777777}));
    chk("merge_pulse_after_wr", 64'((fd_cyc > wr_cyc) && (wr_cyc >= 0)), 64'd1);

    // ---- reset mid-write with 5 entries queued ----
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put_pixel(8'(i), 8'd10, 24'h500000 + 24'(i));
      step();
    end
    pixel_valid = 1'b0;
    step();
    chk("pre_rst_wr_en", 64'(mem_wr_en), 64'd1);
    rst = 1'b1;
    step();
    chk("rst_outputs", {mem_wr_en, busy, frame_done, overflow, clip_cnt, mem_addr, mem_wdata},
        64'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    n0 = wq.size();
    repeat (20) step();
    chk("rst_no_writes", 64'(wq.size() - n0), 64'd0);
    chk("rst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
